// File: rtl/stm1_pkg.sv
// rtl/stm1_pkg.sv - STM-1 frame geometry constants and B2 calculator state encoding
package stm1_pkg;

    localparam int STM1_ROWS = 9;
    localparam int STM1_COLS = 270;
    localparam int RSOH_ROWS = 3;
    localparam int SOH_COLS  = 9;

    typedef enum logic {
        RXB2_HUNT = 1'b0,
        RXB2_ACC  = 1'b1
    } rxb2_state_t;

    // Place a byte into its BIP-8 lane of the 24-bit word: lane 0 is the MSB byte.
    function automatic logic [23:0] bip_lane_word(input logic [1:0] lane, input logic [7:0] d);
        case (lane)
            2'd0:    return {d, 16'h0000};
            2'd1:    return {8'h00, d, 8'h00};
            default: return {16'h0000, d};
        endcase
    endfunction

endpackage

// File: rtl/rxb2_pos.sv
// rtl/rxb2_pos.sv - STM-1 row/column/lane position counter with frame flags
module rxb2_pos
    import stm1_pkg::*;
(
    input  logic       clk19,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       adv_i,
    output logic [1:0] lane_o,
    output logic       lastbyte_o,
    output logic       rsoh_o,
    output logic       atsof_o
);

    logic [3:0] row_q, row_d;
    logic [8:0] col_q, col_d;
    logic [1:0] lane_q, lane_d;

    assign lastbyte_o = (row_q == 4'(STM1_ROWS - 1)) && (col_q == 9'(STM1_COLS - 1));
    assign rsoh_o     = (row_q < 4'(RSOH_ROWS)) && (col_q < 9'(SOH_COLS));
    assign atsof_o    = (row_q == 4'd0) && (col_q == 9'd0);
    assign lane_o     = lane_q;

    // Next position: advance on each byte, wrap at end of row and end of frame.
    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        lane_d = lane_q;
        if (clr_i) begin
            row_d  = 4'd0;
            col_d  = 9'd0;
            lane_d = 2'd0;
        end else if (adv_i) begin
            if (col_q == 9'(STM1_COLS - 1)) begin
                col_d  = 9'd0;
                lane_d = 2'd0;
                row_d  = lastbyte_o ? 4'd0 : row_q + 4'd1;
            end else begin
                col_d  = col_q + 9'd1;
                lane_d = (lane_q == 2'd2) ? 2'd0 : lane_q + 2'd1;
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk19) begin
        if (rst) begin
            row_q  <= 4'd0;
            col_q  <= 9'd0;
            lane_q <= 2'd0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            lane_q <= lane_d;
        end
    end

endmodule

// File: rtl/rx_b2cal.sv
// rtl/rx_b2cal.sv - receive BIP-24 (B2) calculator for STM-1; optional RXB2CAL_ERRINJ_EN error injection
module rx_b2cal
    import stm1_pkg::*;
#(
    parameter logic [23:0] INIT = 24'd0
) (
    input  logic        clk19,
    input  logic        rst,
    input  logic [7:0]  rdat,
    input  logic        en,
    input  logic        rxsof,
    output logic [23:0] b2dat,
    output logic        b2vld,
    output logic        frmerr
`ifdef RXB2CAL_ERRINJ_EN
    ,
    input  logic        errinj
`endif
);

    rxb2_state_t state_q, state_d;
    logic [23:0] acc_q, acc_d;
    logic [23:0] b2dat_q, b2dat_d;
    logic        b2vld_q, b2vld_d;
    logic        frmerr_q, frmerr_d;
    logic [23:0] acc_next;
    logic [23:0] inj_mask;
    logic        pos_clr;
    logic        pos_adv;
    logic [1:0]  lane;
    logic        lastbyte;
    logic        rsoh;
    logic        atsof;

    rxb2_pos u_pos (
        .clk19      (clk19),
        .rst        (rst),
        .clr_i      (pos_clr),
        .adv_i      (pos_adv),
        .lane_o     (lane),
        .lastbyte_o (lastbyte),
        .rsoh_o     (rsoh),
        .atsof_o    (atsof)
    );

`ifdef RXB2CAL_ERRINJ_EN
    logic inj_q, inj_d;

    assign inj_mask = inj_q ? 24'h010000 : 24'h000000;

    // Sticky injection request, consumed by the next delivered result.
    always_comb begin
        inj_d = inj_q;
        if (b2vld_d) begin
            inj_d = 1'b0;
        end
        if (errinj) begin
            inj_d = 1'b1;
        end
    end

    // Injection flag register.
    always_ff @(posedge clk19) begin
        if (rst) begin
            inj_q <= 1'b0;
        end else begin
            inj_q <= inj_d;
        end
    end
`else
    assign inj_mask = 24'h000000;
`endif

    // Running parity with the current byte folded in; RSOH bytes contribute nothing.
    assign acc_next = acc_q ^ (rsoh ? 24'h000000 : bip_lane_word(lane, rdat));

    // FSM next state, accumulator update and output pulses.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        b2dat_d  = b2dat_q;
        b2vld_d  = 1'b0;
        frmerr_d = 1'b0;
        pos_clr  = 1'b0;
        pos_adv  = 1'b0;
        case (state_q)
            RXB2_HUNT: begin
                pos_clr = 1'b1;
                acc_d   = 24'd0;
                if (rxsof) begin
                    state_d = RXB2_ACC;
                end
            end
            RXB2_ACC: begin
                if (rxsof) begin
                    pos_clr  = 1'b1;
                    acc_d    = 24'd0;
                    frmerr_d = !atsof;
                end else if (en) begin
                    pos_adv = 1'b1;
                    if (lastbyte) begin
                        b2dat_d = acc_next ^ inj_mask;
                        b2vld_d = 1'b1;
                        acc_d   = 24'd0;
                    end else begin
                        acc_d = acc_next;
                    end
                end
            end
            default: begin
                state_d = RXB2_HUNT;
            end
        endcase
    end

    // State, accumulator and registered outputs.
    always_ff @(posedge clk19) begin
        if (rst) begin
            state_q  <= RXB2_HUNT;
            acc_q    <= INIT;
            b2dat_q  <= INIT;
            b2vld_q  <= 1'b0;
            frmerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            b2dat_q  <= b2dat_d;
            b2vld_q  <= b2vld_d;
            frmerr_q <= frmerr_d;
        end
    end

    assign b2dat  = b2dat_q;
    assign b2vld  = b2vld_q;
    assign frmerr = frmerr_q;

endmodule

// File: tb/tb_rx_b2cal.sv
// tb/tb_rx_b2cal.sv - scoreboard testbench for rx_b2cal
module tb_rx_b2cal;

    localparam int FRAME_BYTES = 2430;

    logic        clk19;
    logic        rst;
    logic [7:0]  rdat;
    logic        en;
    logic        rxsof;
    logic [23:0] b2dat;
    logic        b2vld;
    logic        frmerr;
`ifdef RXB2CAL_ERRINJ_EN
    logic        errinj;
    bit          inj_pending;
`endif

    typedef struct {
        bit          kind;
        logic [23:0] data;
        int          due;
    } exp_t;

    exp_t        expq[$];
    int          checks;
    int          errors;
    int          cyc;
    logic [7:0]  frame_buf [0:FRAME_BYTES-1];

    rx_b2cal dut (
        .clk19  (clk19),
        .rst    (rst),
        .rdat   (rdat),
        .en     (en),
        .rxsof  (rxsof),
        .b2dat  (b2dat),
        .b2vld  (b2vld),
        .frmerr (frmerr)
`ifdef RXB2CAL_ERRINJ_EN
        ,
        .errinj (errinj)
`endif
    );

    initial clk19 = 1'b0;
    always #5 clk19 = ~clk19;

    always @(posedge clk19) cyc <= cyc + 1;

    function automatic logic [23:0] bip_model();
        logic [7:0] l0, l1, l2;
        int r, c;
        l0 = 8'h00; l1 = 8'h00; l2 = 8'h00;
        for (int i = 0; i < FRAME_BYTES; i++) begin
            r = i / 270;
            c = i % 270;
            if (r < 3 && c < 9) continue;
            case (c % 3)
                0: l0 = l0 ^ frame_buf[i];
                1: l1 = l1 ^ frame_buf[i];
                default: l2 = l2 ^ frame_buf[i];
            endcase
        end
        return {l0, l1, l2};
    endfunction

    task automatic drive(input bit s, input bit e, input logic [7:0] d);
        @(posedge clk19);
        #1;
        rxsof = s;
        en    = e;
        rdat  = d;
`ifdef RXB2CAL_ERRINJ_EN
        errinj = 1'b0;
`endif
    endtask

    task automatic push_exp(input bit kind, input logic [23:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.due  = cyc + 1;
        expq.push_back(e);
    endtask

    task automatic send_frame(input bit gaps);
        logic [23:0] exp_v;
        exp_v = bip_model();
`ifdef RXB2CAL_ERRINJ_EN
        if (inj_pending) begin
            exp_v = exp_v ^ 24'h010000;
            inj_pending = 1'b0;
        end
`endif
        for (int i = 0; i < FRAME_BYTES; i++) begin
            if (gaps && $urandom_range(0, 7) == 0) drive(1'b0, 1'b0, 8'($urandom));
            drive(1'b0, 1'b1, frame_buf[i]);
            if (i == FRAME_BYTES - 1) push_exp(1'b0, exp_v);
        end
    endtask

    task automatic clear_frame();
        for (int i = 0; i < FRAME_BYTES; i++) frame_buf[i] = 8'h00;
    endtask

    task automatic random_frame();
        for (int i = 0; i < FRAME_BYTES; i++) frame_buf[i] = 8'($urandom);
    endtask

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%06h required=%06h", name, act, req);
        end
    endtask

    // Monitor: every output pulse is matched against the oldest expected event.
    always @(negedge clk19) begin
        if (!rst) begin
            if (b2vld) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL b2vld_unexpected cyc=%0d b2dat=%06h required=no_pulse", cyc, b2dat);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    if (e.kind != 1'b0 || e.data !== b2dat || e.due != cyc) begin
                        errors++;
                        $display("FAIL b2dat actual=%06h@%0d required=%06h@%0d kind=%0d",
                                 b2dat, cyc, e.data, e.due, e.kind);
                    end
                end
            end
            if (frmerr) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL frmerr_unexpected cyc=%0d required=no_pulse", cyc);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    if (e.kind != 1'b1 || e.due != cyc) begin
                        errors++;
                        $display("FAIL frmerr actual=pulse@%0d required=kind%0d@%0d", cyc, e.kind, e.due);
                    end
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b1;
        rxsof  = 1'b0;
        en     = 1'b0;
        rdat   = 8'h00;
`ifdef RXB2CAL_ERRINJ_EN
        errinj      = 1'b0;
        inj_pending = 1'b0;
`endif
        repeat (3) drive(1'b0, 1'b0, 8'h00);
        check("reset_b2dat", b2dat, 24'h000000);
        check("reset_b2vld", {23'd0, b2vld}, 24'd0);
        check("reset_frmerr", {23'd0, frmerr}, 24'd0);
        rst = 1'b0;

        // HUNT: bytes without rxsof produce nothing.
        for (int i = 0; i < 300; i++) drive(1'b0, 1'b1, 8'($urandom));

        // Single lane-0 byte outside RSOH.
        drive(1'b1, 1'b0, 8'h00);
        clear_frame();
        frame_buf[3 * 270 + 0] = 8'h01;
        send_frame(1'b0);

        // RSOH byte excluded, lane-1 byte counted.
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        clear_frame();
        frame_buf[0]  = 8'hFF;
        frame_buf[10] = 8'h80;
        send_frame(1'b0);

        // Two back-to-back frames, second one carried by the flywheel.
        drive(1'b1, 1'b0, 8'h00);
        clear_frame();
        frame_buf[5 * 270 + 2] = 8'hAA;
        send_frame(1'b0);
        clear_frame();
        send_frame(1'b0);

        // Short frame: early rxsof after 1000 bytes, then a full random frame.
        drive(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 1000; i++) drive(1'b0, 1'b1, 8'($urandom));
        drive(1'b1, 1'b0, 8'h00);
        push_exp(1'b1, 24'h000000);
        random_frame();
        send_frame(1'b0);

        // Random frame with idle gaps between bytes.
        random_frame();
        send_frame(1'b1);

        // Reset in row 4, then bytes while hunting.
        for (int i = 0; i < 4 * 270 + 5; i++) drive(1'b0, 1'b1, 8'($urandom));
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        check("midrst_b2dat", b2dat, 24'h000000);
        check("midrst_b2vld", {23'd0, b2vld}, 24'd0);
        check("midrst_frmerr", {23'd0, frmerr}, 24'd0);
        rst = 1'b0;
        for (int i = 0; i < 500; i++) drive(1'b0, 1'b1, 8'($urandom));
        check("hunt_b2dat_held", b2dat, 24'h000000);

        // Recovery after reset.
        drive(1'b1, 1'b0, 8'h00);
        random_frame();
        send_frame(1'b1);

`ifdef RXB2CAL_ERRINJ_EN
        drive(1'b1, 1'b0, 8'h00);
        errinj = 1'b1;
        inj_pending = 1'b1;
        clear_frame();
        send_frame(1'b0);
        clear_frame();
        send_frame(1'b0);
`endif

        repeat (5) drive(1'b0, 1'b0, 8'h00);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL pending_events actual=%0d required=0", expq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
